mem_access_ctrl: RTL and testbench

Data-memory access controller for the MEM stage, between the EX/MEM pipeline register and the MEM/WB register. It issues read/write requests to the data cache and holds the pipeline until `dhit`. It owns the LL/SC link register and produces the load or SC-result word, plus the write enable for the MEM/WB register. It also turns a HALT reaching MEM into a sticky halt once no access is outstanding.

---
 rtl/cpu_types_pkg.sv | 12 +
 rtl/mem_access_ctrl_if.sv | 24 ++
 rtl/ll_sc_link.sv | 48 ++++
 rtl/mem_access_ctrl.sv | 96 +++++++++
 tb/tb_mem_access_ctrl.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: the machine word and the MEM-stage access controller states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    HALTED = 2'd2
  } memctrl_state_t;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Data-cache bus between the MEM-stage controller (master) and the cache (slave),
// including the coherence invalidate snoop.
interface mem_access_ctrl_if;
  import cpu_types_pkg::*;

  logic  dmemREN;
  logic  dmemWEN;
  word_t dmemaddr;
  word_t dmemstore;
  logic  dhit;
  word_t dmemload;
  logic  ccinv;
  word_t ccsnoopaddr;

  modport master (
    output dmemREN, dmemWEN, dmemaddr, dmemstore,
    input  dhit, dmemload, ccinv, ccsnoopaddr
  );

  modport slave (
    input  dmemREN, dmemWEN, dmemaddr, dmemstore,
    output dhit, dmemload, ccinv, ccsnoopaddr
  );
endinterface

// File: rtl/ll_sc_link.sv
// LL/SC link register: remembers the word address of the last completed LL and
// decides whether an SC in MEM may proceed.
module ll_sc_link
  import cpu_types_pkg::*;
#(
  parameter int ADDR_LSB = 2
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  ll_done_i,
  input  logic  sc_done_i,
  input  logic  sc_mem_i,
  input  word_t daddr_i,
  input  logic  ccinv_i,
  input  word_t ccsnoopaddr_i,
  output logic  sc_fail_o
);
  localparam int AW = 32 - ADDR_LSB;

  logic          link_valid_q;
  logic [AW-1:0] link_addr_q;
  logic [AW-1:0] daddr_w;
  logic [AW-1:0] snoop_w;
  logic          inv_hit;
  logic          unused_lsb;

  assign daddr_w    = daddr_i[31:ADDR_LSB];
  assign snoop_w    = ccsnoopaddr_i[31:ADDR_LSB];
  assign unused_lsb = ^{daddr_i, ccsnoopaddr_i};

  assign inv_hit   = ccinv_i & (snoop_w == link_addr_q);
  assign sc_fail_o = sc_mem_i & ~(link_valid_q & (daddr_w == link_addr_q) & ~inv_hit);

  // A snoop hit is applied last so it beats a same-cycle LL completion.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      link_valid_q <= 1'b0;
      link_addr_q  <= '0;
    end else begin
      if (ll_done_i) begin
        link_valid_q <= 1'b1;
        link_addr_q  <= daddr_w;
      end
      if (sc_done_i || inv_hit) link_valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: issues cache requests, stalls the
// pipeline on misses, muxes load / SC results and latches a sticky HALT.
module mem_access_ctrl
  import cpu_types_pkg::*;
#(
  parameter int ADDR_LSB = 2
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               valid_mem,
  input  logic               dREN_mem,
  input  logic               dWEN_mem,
  input  logic               ll_mem,
  input  logic               sc_mem,
  input  logic               halt_mem,
  input  word_t              daddr_mem,
  input  word_t              dstore_mem,
  mem_access_ctrl_if.master  dbus,
  output logic               mem_stall,
  output logic               enable_memwb,
  output word_t              dmemload_out,
  output logic               halt_out
);

  memctrl_state_t state_q, state_d, st_cur;
  logic vld, is_mem, active, req, sc_fail, ll_done, sc_done;

  // During reset the block behaves as an idle stage holding a bubble.
  assign st_cur = RST ? IDLE : state_q;
  assign vld    = valid_mem & ~RST;
  assign active = (st_cur != HALTED);
  assign is_mem = vld & (dREN_mem | dWEN_mem);
  assign req    = is_mem & active & ~sc_fail;

  assign dbus.dmemREN   = req & dREN_mem;
  assign dbus.dmemWEN   = req & dWEN_mem;
  assign dbus.dmemaddr  = daddr_mem;
  assign dbus.dmemstore = dstore_mem;

  assign ll_done = req & ll_mem & dbus.dhit;
  assign sc_done = vld & active & sc_mem & (dbus.dhit | sc_fail);

  ll_sc_link #(.ADDR_LSB(ADDR_LSB)) u_link (
    .clk_i         (CLK),
    .rst_i         (RST),
    .ll_done_i     (ll_done),
    .sc_done_i     (sc_done),
    .sc_mem_i      (sc_mem),
    .daddr_i       (daddr_mem),
    .ccinv_i       (dbus.ccinv),
    .ccsnoopaddr_i (dbus.ccsnoopaddr),
    .sc_fail_o     (sc_fail)
  );

  always_comb begin
    state_d      = st_cur;
    mem_stall    = 1'b0;
    enable_memwb = 1'b0;
    unique case (st_cur)
      IDLE: begin
        if (req && !dbus.dhit) begin
          state_d   = WAIT;
          mem_stall = 1'b1;
        end else begin
          enable_memwb = 1'b1;
          if (vld && halt_mem && !is_mem) state_d = HALTED;
        end
      end
      WAIT: begin
        // A snoop can kill a waiting SC; that also retires the instruction.
        if (req && !dbus.dhit) begin
          mem_stall = 1'b1;
        end else begin
          enable_memwb = 1'b1;
          state_d      = IDLE;
        end
      end
      HALTED: mem_stall = 1'b1;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dmemload_out = '0;
    if (vld && active && sc_mem) dmemload_out = {31'b0, ~sc_fail};
    else if (vld && active && dREN_mem) dmemload_out = dbus.dmemload;
  end

  assign halt_out = (st_cur == HALTED);

  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized self-checking bench for mem_access_ctrl against an instruction-level model.
module tb_mem_access_ctrl;
  import cpu_types_pkg::*;

  typedef enum int {OP_NOP, OP_BUB, OP_LD, OP_ST, OP_LL, OP_SC, OP_HALT} op_e;

  logic  CLK = 1'b0;
  logic  RST;
  logic  valid_mem, dREN_mem, dWEN_mem, ll_mem, sc_mem, halt_mem;
  word_t daddr_mem, dstore_mem;
  logic  mem_stall, enable_memwb, halt_out;
  word_t dmemload_out;

  mem_access_ctrl_if dbus ();

  mem_access_ctrl #(.ADDR_LSB(2)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .valid_mem    (valid_mem),
    .dREN_mem     (dREN_mem),
    .dWEN_mem     (dWEN_mem),
    .ll_mem       (ll_mem),
    .sc_mem       (sc_mem),
    .halt_mem     (halt_mem),
    .daddr_mem    (daddr_mem),
    .dstore_mem   (dstore_mem),
    .dbus         (dbus),
    .mem_stall    (mem_stall),
    .enable_memwb (enable_memwb),
    .dmemload_out (dmemload_out),
    .halt_out     (halt_out)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  // Architectural model: link register (word address) and halt flag.
  bit          m_lv;
  logic [29:0] m_la;
  bit          m_halted;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    valid_mem = 0; dREN_mem = 0; dWEN_mem = 0; ll_mem = 0; sc_mem = 0; halt_mem = 0;
    daddr_mem = '0; dstore_mem = '0;
    dbus.dhit = 0; dbus.dmemload = '0; dbus.ccinv = 0; dbus.ccsnoopaddr = '0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    idle_inputs();
    dbus.dmemload = 32'hA5A5_A5A5;
    RST = 1;
    #2;
    chk("rst_ren",  {31'b0, dbus.dmemREN}, 0);
    chk("rst_wen",  {31'b0, dbus.dmemWEN}, 0);
    chk("rst_stall",{31'b0, mem_stall}, 0);
    chk("rst_en",   {31'b0, enable_memwb}, 1);
    chk("rst_out",  dmemload_out, 0);
    chk("rst_halt", {31'b0, halt_out}, 0);
    @(negedge CLK);
    RST = 0;
    m_lv = 0; m_la = '0; m_halted = 0;
  endtask

  // Apply one instruction in MEM; the cache answers dhit after lat cycles.
  task automatic apply(input op_e op, input word_t addr, input word_t sd, input int lat,
                       input bit inv, input word_t snoop);
    bit ld, st, sc, inv_hit0, sc_ok, busy, last;
    int ncyc;
    word_t ld_data, exp_out;
    ld       = (op == OP_LD) || (op == OP_LL);
    st       = (op == OP_ST) || (op == OP_SC);
    sc       = (op == OP_SC);
    inv_hit0 = inv && (snoop[31:2] == m_la);
    sc_ok    = m_lv && (addr[31:2] == m_la) && !inv_hit0;
    busy     = !m_halted && (ld || st) && !(sc && !sc_ok);
    ncyc     = busy ? lat + 1 : 1;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge CLK);
      valid_mem  = (op != OP_BUB);
      dREN_mem   = ld || (op == OP_BUB);
      dWEN_mem   = st;
      ll_mem     = (op == OP_LL);
      sc_mem     = sc;
      halt_mem   = (op == OP_HALT);
      daddr_mem  = addr;
      dstore_mem = sd;
      dbus.dhit  = busy ? (c == lat) : 1'($urandom_range(0, 1));
      ld_data    = $urandom;
      dbus.dmemload    = ld_data;
      dbus.ccinv       = inv && (c == 0);
      dbus.ccsnoopaddr = snoop;
      last = (c == ncyc - 1);
      #2;
      if (m_halted) begin
        chk("h_ren",   {31'b0, dbus.dmemREN}, 0);
        chk("h_wen",   {31'b0, dbus.dmemWEN}, 0);
        chk("h_stall", {31'b0, mem_stall}, 1);
        chk("h_en",    {31'b0, enable_memwb}, 0);
        chk("h_halt",  {31'b0, halt_out}, 1);
      end else begin
        chk("ren",   {31'b0, dbus.dmemREN}, {31'b0, busy && ld});
        chk("wen",   {31'b0, dbus.dmemWEN}, {31'b0, busy && st});
        chk("stall", {31'b0, mem_stall}, {31'b0, busy && !last});
        chk("en",    {31'b0, enable_memwb}, {31'b0, last});
        chk("halt",  {31'b0, halt_out}, 0);
        if (busy) begin
          chk("addr",  dbus.dmemaddr, addr);
          chk("store", dbus.dmemstore, sd);
        end
        if (last) begin
          exp_out = (op == OP_BUB) ? 32'h0 : sc ? {31'b0, sc_ok} : ld ? ld_data : 32'h0;
          chk("out", dmemload_out, exp_out);
        end
      end
    end
    if (inv_hit0) m_lv = 0;
    if (!m_halted) begin
      if (op == OP_LL) begin
        m_la = addr[31:2];
        m_lv = !(inv_hit0 && lat == 0);
      end
      if (sc) m_lv = 0;
      if (op == OP_HALT) m_halted = 1;
    end
  endtask

  function automatic word_t pick_addr();
    word_t base [4] = '{32'h100, 32'h200, 32'h300, 32'h304};
    return base[$urandom_range(0, 3)] | word_t'($urandom_range(0, 3));
  endfunction

  initial begin
    op_e op;
    word_t snoop;
    bit inv;
    idle_inputs();
    RST = 1;
    m_lv = 0; m_la = '0; m_halted = 0;
    do_reset();

    // Directed scenarios
    apply(OP_LD, 32'h100, 0, 0, 0, 0);
    apply(OP_ST, 32'h200, 32'h1234_5678, 3, 0, 0);
    apply(OP_LL, 32'h300, 0, 0, 0, 0);
    apply(OP_SC, 32'h300, 32'h77, 1, 0, 0);
    apply(OP_SC, 32'h300, 32'h77, 0, 0, 0);
    apply(OP_LL, 32'h300, 0, 2, 0, 0);
    apply(OP_SC, 32'h300, 32'h77, 0, 1, 32'h302);
    apply(OP_LL, 32'h300, 0, 0, 1, 32'h300);
    apply(OP_SC, 32'h300, 32'h77, 0, 0, 0);
    apply(OP_LD, 32'h100, 0, 2, 0, 0);
    apply(OP_HALT, 0, 0, 0, 0, 0);
    apply(OP_LD, 32'h100, 0, 0, 0, 0);
    apply(OP_ST, 32'h200, 5, 0, 0, 0);
    do_reset();

    // Reset while a load is waiting on the cache
    apply(OP_LL, 32'h300, 0, 0, 0, 0);
    @(negedge CLK);
    valid_mem = 1; dREN_mem = 1; dWEN_mem = 0; ll_mem = 0; sc_mem = 0; halt_mem = 0;
    daddr_mem = 32'h100; dbus.dhit = 0; dbus.ccinv = 0;
    #2;
    chk("w_stall", {31'b0, mem_stall}, 1);
    @(negedge CLK);
    RST = 1;
    #2;
    chk("wr_ren",   {31'b0, dbus.dmemREN}, 0);
    chk("wr_stall", {31'b0, mem_stall}, 0);
    @(negedge CLK);
    RST = 0;
    idle_inputs();
    m_lv = 0; m_halted = 0;
    #2;
    chk("wr_idle_en", {31'b0, enable_memwb}, 1);
    apply(OP_SC, 32'h300, 32'h9, 0, 0, 0);

    // Randomized instruction stream
    for (int i = 0; i < 400; i++) begin
      if (m_halted && $urandom_range(0, 2) == 0) do_reset();
      case ($urandom_range(0, 19))
        0, 1:       op = OP_NOP;
        2, 3:       op = OP_BUB;
        4, 5, 6, 7: op = OP_LD;
        8, 9, 10:   op = OP_ST;
        11, 12, 13: op = OP_LL;
        14, 15, 16, 17: op = OP_SC;
        18:         op = OP_HALT;
        default:    op = OP_NOP;
      endcase
      inv   = ($urandom_range(0, 3) == 0);
      snoop = $urandom_range(0, 1) ? {m_la, 2'($urandom_range(0, 3))} : pick_addr();
      apply(op, pick_addr(), $urandom, $urandom_range(0, 3), inv, snoop);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
